// File: rtl/filter_pkg.sv
// filter_pkg -- shared definitions for the filter datapath front end.
//   hb_state_t   : histogram_builder FSM states
//   bin_count    : number of histogram bins for a given pixel width
//   pixel_count  : number of pixels in a W x H image
//   DEF_*        : default image geometry
package filter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SCAN,
        DRAIN,
        PREFIX,
        DONE
    } hb_state_t;

    localparam int DEF_IMAGE_WIDTH  = 320;
    localparam int DEF_IMAGE_HEIGHT = 240;
    localparam int DEF_PIXEL_WIDTH  = 8;

    function automatic int bin_count(input int pw);
        return 1 << pw;
    endfunction

    function automatic int pixel_count(input int w, input int h);
        return w * h;
    endfunction

endpackage

// File: rtl/histogram_prefix_unit.sv
// histogram_prefix_unit -- rewrites the histogram RAM in place as a CDF.
// Reads bin k in pipeline cycle k and writes the running sum for bin k-1
// in the same cycle (bins differ, so the read-first RAM never conflicts).
// Ports:
//   clk, rst      clock, async active-low reset
//   clear         clears cdf_min (new run accepted)
//   active        high while the FSM is in PREFIX
//   rdata         histogram RAM read data (1-cycle latency)
//   raddr/waddr/wdata/we  histogram RAM port drive
//   last          final write cycle of the pass
//   cdf_min       first non-zero running sum of the pass
module histogram_prefix_unit #(
    parameter int AW = 8,
    parameter int DW = 17
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          active,
    input  logic [DW-1:0] rdata,
    output logic [AW-1:0] raddr,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    output logic          we,
    output logic          last,
    output logic [DW-1:0] cdf_min
);

    // cnt runs 0..2^AW: 2^AW reads followed by one trailing write.
    logic [AW:0]   cnt;
    logic [AW:0]   cnt_m1;
    logic [DW-1:0] acc;
    logic [DW-1:0] acc_nxt;

    assign cnt_m1  = cnt - (AW+1)'(1);
    assign acc_nxt = acc + rdata;
    assign raddr   = cnt[AW-1:0];
    assign we      = active && (cnt != '0);
    assign waddr   = cnt_m1[AW-1:0];
    assign wdata   = we ? acc_nxt : '0;
    assign last    = active && cnt[AW];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            acc     <= '0;
            cdf_min <= '0;
        end else begin
            if (active) begin
                cnt <= cnt + (AW+1)'(1);
                if (we) acc <= acc_nxt;
            end else begin
                cnt <= '0;
                acc <= '0;
            end
            // Once latched, cdf_min is non-zero and never re-latches.
            if (clear)
                cdf_min <= '0;
            else if (we && cdf_min == '0 && acc_nxt != '0)
                cdf_min <= acc_nxt;
        end
    end

endmodule

// File: rtl/histogram_builder.sv
// histogram_builder -- scans the image RAM, builds the per-intensity
// histogram in the histogram RAM and, with HISTOGRAM_BUILDER_CDF_EN defined,
// rewrites it in place as the CDF and reports cdf_min. Without the macro the
// PREFIX pass is skipped, the RAM keeps raw counts and cdf_min is 0.
// Ports:
//   clk, rst                     clock, async active-low reset
//   start                        run request (sampled in IDLE only)
//   is_image_RAM_available       image RAM may be read this cycle
//   image_RAM_data/CE/address    image RAM read port (1-cycle latency)
//   histogram_RAM_raddr/rdata    histogram RAM read port (read-first)
//   histogram_RAM_waddr/wdata/WE histogram RAM write port
//   busy, done, cdf_min          status / result
module histogram_builder
    import filter_pkg::*;
#(
    parameter int IMAGE_WIDTH                 = DEF_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT                = DEF_IMAGE_HEIGHT,
    parameter int PIXEL_WIDTH                 = DEF_PIXEL_WIDTH,
    parameter int HISTOGRAM_RAM_ADDRESS_WIDTH = PIXEL_WIDTH,
    parameter int HISTOGRAM_RAM_DATA_WIDTH    = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT+1),
    parameter int IMAGE_RAM_ADDRESS_WIDTH     = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   is_image_RAM_available,
    input  logic [PIXEL_WIDTH-1:0]                 image_RAM_data,
    output logic                                   image_RAM_CE,
    output logic [IMAGE_RAM_ADDRESS_WIDTH-1:0]     image_RAM_address,
    output logic [HISTOGRAM_RAM_ADDRESS_WIDTH-1:0] histogram_RAM_raddr,
    input  logic [HISTOGRAM_RAM_DATA_WIDTH-1:0]    histogram_RAM_rdata,
    output logic [HISTOGRAM_RAM_ADDRESS_WIDTH-1:0] histogram_RAM_waddr,
    output logic [HISTOGRAM_RAM_DATA_WIDTH-1:0]    histogram_RAM_wdata,
    output logic                                   histogram_RAM_WE,
    output logic                                   busy,
    output logic                                   done,
    output logic [HISTOGRAM_RAM_DATA_WIDTH-1:0]    cdf_min
);

    localparam int NUM_BINS   = bin_count(PIXEL_WIDTH);
    localparam int NUM_PIXELS = pixel_count(IMAGE_WIDTH, IMAGE_HEIGHT);
    localparam int AW = HISTOGRAM_RAM_ADDRESS_WIDTH;
    localparam int DW = HISTOGRAM_RAM_DATA_WIDTH;
    localparam int IW = IMAGE_RAM_ADDRESS_WIDTH;

    hb_state_t     state, state_nxt;
    logic [AW-1:0] clr_cnt;
    logic [IW-1:0] addr_cnt;
    logic          drain_phase;
    logic          issue, last_issue;

    // Scan pipeline: S1 = pixel returned, S2 = count returned.
    logic          s1_vld, s2_vld, prev_vld;
    logic [AW-1:0] s2_bin, prev_bin;
    logic [DW-1:0] prev_wdata, scan_wdata;

    assign issue      = (state == SCAN) && is_image_RAM_available;
    assign last_issue = issue && (addr_cnt == IW'(NUM_PIXELS-1));
    assign image_RAM_address = addr_cnt;

    // The read for this S2 pixel was issued in the same cycle the previous
    // pixel wrote its bin; a read-first RAM returns the stale count, so take
    // the value just written instead.
    assign scan_wdata = ((prev_vld && prev_bin == s2_bin) ? prev_wdata
                                                          : histogram_RAM_rdata) + DW'(1);

`ifdef HISTOGRAM_BUILDER_CDF_EN
    logic [AW-1:0] pfx_raddr, pfx_waddr;
    logic [DW-1:0] pfx_wdata;
    logic          pfx_we, pfx_last;

    histogram_prefix_unit #(.AW(AW), .DW(DW)) u_prefix (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == IDLE && start),
        .active  (state == PREFIX),
        .rdata   (histogram_RAM_rdata),
        .raddr   (pfx_raddr),
        .waddr   (pfx_waddr),
        .wdata   (pfx_wdata),
        .we      (pfx_we),
        .last    (pfx_last),
        .cdf_min (cdf_min)
    );
`else
    assign cdf_min = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (start) state_nxt = CLEAR;
            CLEAR:  if (clr_cnt == AW'(NUM_BINS-1)) state_nxt = SCAN;
            SCAN:   if (last_issue) state_nxt = DRAIN;
`ifdef HISTOGRAM_BUILDER_CDF_EN
            DRAIN:  if (drain_phase) state_nxt = PREFIX;
            PREFIX: if (pfx_last) state_nxt = DONE;
`else
            DRAIN:  if (drain_phase) state_nxt = DONE;
            PREFIX: state_nxt = DONE;
`endif
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clr_cnt     <= '0;
            addr_cnt    <= '0;
            drain_phase <= 1'b0;
            s1_vld      <= 1'b0;
            s2_vld      <= 1'b0;
            s2_bin      <= '0;
            prev_vld    <= 1'b0;
            prev_bin    <= '0;
            prev_wdata  <= '0;
        end else begin
            // clr_cnt wraps to 0 on its last CLEAR cycle.
            if (state == CLEAR) clr_cnt <= clr_cnt + AW'(1);
            if (last_issue)     addr_cnt <= '0;
            else if (issue)     addr_cnt <= addr_cnt + IW'(1);
            if (state == DRAIN) drain_phase <= ~drain_phase;
            s1_vld     <= issue;
            s2_vld     <= s1_vld;
            if (s1_vld) s2_bin <= AW'(image_RAM_data);
            prev_vld   <= s2_vld;
            prev_bin   <= s2_bin;
            prev_wdata <= scan_wdata;
        end
    end

    always_comb begin
        image_RAM_CE        = issue;
        histogram_RAM_raddr = '0;
        histogram_RAM_waddr = '0;
        histogram_RAM_wdata = '0;
        histogram_RAM_WE    = 1'b0;
        busy                = (state != IDLE) && (state != DONE);
        done                = (state == DONE);
        case (state)
            CLEAR: begin
                histogram_RAM_WE    = 1'b1;
                histogram_RAM_waddr = clr_cnt;
            end
            SCAN, DRAIN: begin
                if (s1_vld) histogram_RAM_raddr = AW'(image_RAM_data);
                if (s2_vld) begin
                    histogram_RAM_WE    = 1'b1;
                    histogram_RAM_waddr = s2_bin;
                    histogram_RAM_wdata = scan_wdata;
                end
            end
`ifdef HISTOGRAM_BUILDER_CDF_EN
            PREFIX: begin
                histogram_RAM_raddr = pfx_raddr;
                histogram_RAM_waddr = pfx_waddr;
                histogram_RAM_wdata = pfx_wdata;
                histogram_RAM_WE    = pfx_we;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: doc/histogram_builder.md
# histogram_builder

Upstream stage of the filter datapath. Scans the full image in the image RAM, builds the per-intensity histogram in the histogram RAM, then optionally rewrites that RAM in place as the cumulative distribution (CDF) and reports the minimum non-zero CDF value. The filter's histogram-equalization path reads the CDF from the histogram RAM and takes `cdf_min` as its `cdf_min` input.

## Interface
- IMAGE_WIDTH, 320, pixels per row
- IMAGE_HEIGHT, 240, rows per image
- PIXEL_WIDTH, 8, bits per pixel; number of bins = 2^PIXEL_WIDTH
- HISTOGRAM_RAM_ADDRESS_WIDTH, PIXEL_WIDTH, bin address width
- HISTOGRAM_RAM_DATA_WIDTH, clog2(IMAGE_WIDTH*IMAGE_HEIGHT+1), count width
- IMAGE_RAM_ADDRESS_WIDTH, clog2(IMAGE_WIDTH*IMAGE_HEIGHT), image address width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- is_image_RAM_available  in  1  high = image RAM may be read this cycle
- image_RAM_data  in  PIXEL_WIDTH  pixel, valid 1 cycle after CE
- image_RAM_CE  out  1  image read strobe
- image_RAM_address  out  IMAGE_RAM_ADDRESS_WIDTH  raster address
- histogram_RAM_raddr  out  HISTOGRAM_RAM_ADDRESS_WIDTH  read address
- histogram_RAM_rdata  in  HISTOGRAM_RAM_DATA_WIDTH  read data, 1-cycle latency, read-first
- histogram_RAM_waddr  out  HISTOGRAM_RAM_ADDRESS_WIDTH  write address
- histogram_RAM_wdata  out  HISTOGRAM_RAM_DATA_WIDTH  write data
- histogram_RAM_WE  out  1  write enable
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle completion pulse
- cdf_min  out  HISTOGRAM_RAM_DATA_WIDTH  first non-zero CDF value, held until next start

## Operation
- FSM states: IDLE, CLEAR, SCAN, DRAIN, PREFIX, DONE.
- IDLE: `start`=1 → CLEAR, clear `cdf_min` to 0. `start` in any other state is ignored.
- CLEAR: writes 0 to bins 0..2^PW−1, one per cycle (WE=1, waddr=bin counter) → SCAN.
- SCAN is a three-stage pipeline.
  - S0: when `is_image_RAM_available`=1, assert CE with the address counter (0..W*H−1) and increment it.
  - S1: pixel arrives; issue raddr=pixel.
  - S2: rdata arrives; write pixel's count+1.
  - Forwarding: if the S2 bin equals the S2 bin of the previous cycle, use the previously written value instead of rdata. This covers consecutive equal pixels through the read-first RAM.
  - When `is_image_RAM_available`=0, no CE is issued and in-flight stages still advance. After the last address is issued → DRAIN.
- DRAIN: 2 cycles to retire S1/S2 → PREFIX (or DONE when the macro is absent).
- PREFIX: reads bins 0..2^PW−1 in successive cycles. One cycle later the accumulator acc += rdata and acc is written back to the same bin. The first cycle in which acc becomes non-zero latches `cdf_min`=acc. Total cycles: 2^PW+1 → DONE.
- DONE: `done`=1 for one cycle, `busy`=0 → IDLE.
- Arithmetic: counts and acc are unsigned HISTOGRAM_RAM_DATA_WIDTH bits. W*H fits, so no saturation is needed. The final CDF bin equals W*H.
- Reset (any time, including mid-scan):
  - State returns to IDLE.
  - All outputs reset to 0: CE, WE, addresses, wdata, busy, done, cdf_min.
  - RAM contents are undefined afterwards.

## Timing
- Count cycles from the first CLEAR cycle, which is the cycle after `start` is sampled.
- With no stalls, per-state cycle counts are CLEAR 2^PW, SCAN W*H, DRAIN 2, PREFIX 2^PW+1, DONE 1.
- `done` is high in cycle 2·2^PW + W*H + 4. With defaults, that is cycle 77316.
- Each stall cycle (`is_image_RAM_available`=0 during SCAN) adds exactly one cycle.
- Throughput: 1 pixel/cycle, with the RAM read and write ports both active in the same cycle.

## Configuration
- Macro `HISTOGRAM_BUILDER_CDF_EN`.
- Defined: PREFIX state is present, the RAM holds the CDF at done, and `cdf_min` is valid.
- Undefined: PREFIX is omitted, DRAIN → DONE, the RAM holds raw counts, and `cdf_min` is tied to 0.
- Without the macro, latency is 2^PW + W*H + 3.

## Structure
- Shared package `filter_pkg`: FSM state enum, and the derived width constants (bin count, pixel count).
- One sub-module, `histogram_prefix_unit`, implements the PREFIX read/accumulate/write pipeline and the `cdf_min` latch. It is instantiated only under `HISTOGRAM_BUILDER_CDF_EN`.

## Test plan
- Uniform image, all 0x80, defaults, macro on → bins 0..127 = 0, bins 128..255 = 76800, `cdf_min`=76800, `done` at cycle 77316. This also exercises forwarding on every pixel.
- W=H=16, pixel[i]=i → CDF[i]=i+1, `cdf_min`=1, no-stall latency 2·256+256+4 = 772.
- W=H=16, alternating 5,5,9,5 pattern → CDF[5]=192, CDF[9]=256, `cdf_min`=192. This checks forwarding across consecutive and non-consecutive repeats.
- Same ramp with `is_image_RAM_available` low for 10 random cycles in SCAN → identical RAM contents, `done` 10 cycles later.
- `rst` asserted mid-SCAN then released, followed by a new start → all outputs 0 during reset, and the second run produces correct results. A `start` pulse while `busy` has no effect.
- Macro undefined, uniform 0x00 image, W=H=16 → bin 0 = 256, `cdf_min`=0, `done` at cycle 2^PW + W*H + 3 = 515.
